// File: rtl/tex_clut_fetch_if.sv
// Bus bundle for tex_clut_fetch.
// Carries three groups of signals:
//   - texel request from the addressing stage: i_texValid, o_texReady, i_texelAdress, i_subU
//   - VRAM read port towards the arbiter: o_memReq, o_memAdr, i_memAck, i_memDataValid, i_memData
//   - colour result to the pixel pipeline: o_pixValid, i_pixReady, o_pixColor
// Signal names are given from the fetch block's point of view.
// The slave modport is the fetch block. The master modport is its environment.
interface tex_clut_fetch_if;
    localparam int unsigned ADR_W  = 19;
    localparam int unsigned DATA_W = 16;

    logic              i_texValid;
    logic              o_texReady;
    logic [ADR_W-1:0]  i_texelAdress;
    logic [1:0]        i_subU;

    logic              o_memReq;
    logic [ADR_W-1:0]  o_memAdr;
    logic              i_memAck;
    logic              i_memDataValid;
    logic [DATA_W-1:0] i_memData;

    logic              o_pixValid;
    logic              i_pixReady;
    logic [DATA_W-1:0] o_pixColor;

    modport slave (
        input  i_texValid, i_texelAdress, i_subU,
        input  i_memAck, i_memDataValid, i_memData,
        input  i_pixReady,
        output o_texReady, o_memReq, o_memAdr, o_pixValid, o_pixColor
    );

    modport master (
        output i_texValid, i_texelAdress, i_subU,
        output i_memAck, i_memDataValid, i_memData,
        output i_pixReady,
        input  o_texReady, o_memReq, o_memAdr, o_pixValid, o_pixColor
    );
endinterface

// File: rtl/tex_clut_fetch.sv
// Texture fetch with CLUT lookup.
// Per pixel, the block does three things:
//   1. Takes one halfword texel address.
//   2. Reads that halfword from VRAM. The read is skipped if the one-entry texel cache hits.
//   3. Produces the colour:
//        - 16-bit and reserved formats: the halfword is the colour.
//        - 4/8-bit formats: extract a palette index, then read the CLUT entry.
//          The read is skipped if the one-entry CLUT cache hits.
// Ports:
//   clk, rst           clock and synchronous active-high reset
//   GPU_REG_TexFormat  texture format: 0=4bit, 1=8bit, 2/3=direct 16bit
//   GPU_REG_CLUTx/y    CLUT base (X in 16-halfword units, Y line)
//   i_invalidate       drop both cache entries
//   bus                texel request, VRAM read port and colour output (slave modport)
module tex_clut_fetch (
    input  logic            clk,
    input  logic            rst,
    input  logic [1:0]      GPU_REG_TexFormat,
    input  logic [5:0]      GPU_REG_CLUTx,
    input  logic [8:0]      GPU_REG_CLUTy,
    input  logic            i_invalidate,
    tex_clut_fetch_if.slave bus
);
    localparam int unsigned ADR_W  = 19;
    localparam int unsigned DATA_W = 16;
    localparam int unsigned IDX_W  = 8;
    localparam int unsigned LINE_W = 10;

    typedef enum logic [2:0] {
        IDLE,
        TEX_REQ,
        TEX_WAIT,
        INDEX,
        CLUT_REQ,
        CLUT_WAIT,
        OUT
    } fetchState_t;

    fetchState_t       state;
    fetchState_t       stateNext;

    // Request parameters captured at accept.
    logic [ADR_W-1:0]  lAdr;
    logic [1:0]        lSubU;
    logic [1:0]        lFmt;
    logic [5:0]        lClutX;
    logic [8:0]        lClutY;

    // Halfword for the pixel currently in flight.
    logic [DATA_W-1:0] halfWord;

    // One-entry texel and CLUT caches.
    logic              texVld;
    logic [ADR_W-1:0]  texTag;
    logic [DATA_W-1:0] texData;
    logic              clutVld;
    logic [ADR_W-1:0]  clutTag;
    logic [DATA_W-1:0] clutData;

    // Next values for the registered outputs.
    logic              memReqNext;
    logic [ADR_W-1:0]  memAdrNext;
    logic [DATA_W-1:0] pixColorNext;

    logic              accept;
    logic              texHit;
    logic              clutHit;
    logic              fmtDirect;
    logic              texFill;
    logic              clutFill;
    logic [3:0]        nibble;
    logic [IDX_W-1:0]  idx;
    logic [LINE_W-1:0] clutX;
    logic [ADR_W-1:0]  clutAdr;

    assign accept    = (state == IDLE) && bus.i_texValid && bus.o_texReady;
    assign texHit    = texVld && (texTag == bus.i_texelAdress);
    assign fmtDirect = lFmt[1];
    assign texFill   = (state == TEX_WAIT) && bus.i_memDataValid;
    assign clutFill  = (state == CLUT_WAIT) && bus.i_memDataValid;
    assign clutAdr   = {lClutY, clutX};
    assign clutHit   = clutVld && (clutTag == clutAdr);

    // Palette index extraction and CLUT address.
    // The X sum wraps within the CLUT line and never carries into Y.
    always_comb begin
        nibble = 4'd0;
        idx    = '0;
        case (lSubU)
            2'd0: nibble = halfWord[3:0];
            2'd1: nibble = halfWord[7:4];
            2'd2: nibble = halfWord[11:8];
            2'd3: nibble = halfWord[15:12];
            default: nibble = 4'd0;
        endcase
        if (lFmt == 2'd0) begin
            idx = {4'd0, nibble};
        end else begin
            idx = lSubU[0] ? halfWord[15:8] : halfWord[7:0];
        end
        clutX = LINE_W'({lClutX, 4'd0}) + LINE_W'({2'd0, idx});
    end

    // Next-state and next-output logic.
    always_comb begin
        stateNext    = state;
        memReqNext   = 1'b0;
        memAdrNext   = bus.o_memAdr;
        pixColorNext = bus.o_pixColor;
        case (state)
            IDLE: begin
                if (accept) begin
                    if (texHit) begin
                        stateNext = INDEX;
                    end else begin
                        stateNext  = TEX_REQ;
                        memReqNext = 1'b1;
                        memAdrNext = bus.i_texelAdress;
                    end
                end
            end
            TEX_REQ: begin
                if (bus.i_memAck) begin
                    stateNext = TEX_WAIT;
                end else begin
                    memReqNext = 1'b1;
                end
            end
            TEX_WAIT: begin
                if (bus.i_memDataValid) begin
                    stateNext = INDEX;
                end
            end
            INDEX: begin
                if (fmtDirect) begin
                    pixColorNext = halfWord;
                    stateNext    = OUT;
                end else if (clutHit) begin
                    pixColorNext = clutData;
                    stateNext    = OUT;
                end else begin
                    stateNext  = CLUT_REQ;
                    memReqNext = 1'b1;
                    memAdrNext = clutAdr;
                end
            end
            CLUT_REQ: begin
                if (bus.i_memAck) begin
                    stateNext = CLUT_WAIT;
                end else begin
                    memReqNext = 1'b1;
                end
            end
            CLUT_WAIT: begin
                if (bus.i_memDataValid) begin
                    pixColorNext = bus.i_memData;
                    stateNext    = OUT;
                end
            end
            OUT: begin
                if (bus.i_pixReady) begin
                    stateNext = IDLE;
                end
            end
            default: stateNext = IDLE;
        endcase
    end

    // State and registered outputs.
    always_ff @(posedge clk) begin
        if (rst) begin
            state          <= IDLE;
            bus.o_texReady <= 1'b1;
            bus.o_memReq   <= 1'b0;
            bus.o_memAdr   <= '0;
            bus.o_pixValid <= 1'b0;
            bus.o_pixColor <= '0;
        end else begin
            state          <= stateNext;
            bus.o_texReady <= (stateNext == IDLE);
            bus.o_memReq   <= memReqNext;
            bus.o_memAdr   <= memAdrNext;
            bus.o_pixValid <= (stateNext == OUT);
            bus.o_pixColor <= pixColorNext;
        end
    end

    // Request capture, in-flight halfword and cache maintenance.
    // Invalidate has priority over a fill in the same cycle.
    // The filled data still reaches the current pixel through halfWord or pixColorNext.
    always_ff @(posedge clk) begin
        if (rst) begin
            lAdr     <= '0;
            lSubU    <= '0;
            lFmt     <= '0;
            lClutX   <= '0;
            lClutY   <= '0;
            halfWord <= '0;
            texVld   <= 1'b0;
            texTag   <= '0;
            texData  <= '0;
            clutVld  <= 1'b0;
            clutTag  <= '0;
            clutData <= '0;
        end else begin
            if (accept) begin
                lAdr   <= bus.i_texelAdress;
                lSubU  <= bus.i_subU;
                lFmt   <= GPU_REG_TexFormat;
                lClutX <= GPU_REG_CLUTx;
                lClutY <= GPU_REG_CLUTy;
                if (texHit) begin
                    halfWord <= texData;
                end
            end
            if (texFill) begin
                halfWord <= bus.i_memData;
                texTag   <= lAdr;
                texData  <= bus.i_memData;
            end
            if (clutFill) begin
                clutTag  <= bus.o_memAdr;
                clutData <= bus.i_memData;
            end
            if (i_invalidate) begin
                texVld  <= 1'b0;
                clutVld <= 1'b0;
            end else begin
                if (texFill) begin
                    texVld <= 1'b1;
                end
                if (clutFill) begin
                    clutVld <= 1'b1;
                end
            end
        end
    end
endmodule
